// File: rtl/mapping_pkg.sv
// Shared constants and state encoding for the compaction/scatter pair.
// Default geometry matches the upstream compaction stage.
package mapping_pkg;
  localparam int DEF_BS  = 16;
  localparam int DEF_DW  = 8;
  localparam int BS_BITS = $clog2(DEF_BS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/mapping_scatter_lowest_one_enc.sv
// Priority encoder: index of the lowest set bit (bit 0 = i_vec[0]) plus an any-set flag.
// Purely combinational.
module lowest_one_enc
  import mapping_pkg::*;
#(
  parameter int BS = DEF_BS,
  parameter int IW = BS_BITS
) (
  input  logic [0:BS-1] i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  // Scan downwards so the lowest set index is the final assignment.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mapping_scatter.sv
// Restores compacted beats to their original slot positions; emits the full vector when all selected slots fill.
// MAPPING_SCATTER_HOLD_EN: unselected slots keep the previous frame's data instead of being zeroed on load.
module mapping_scatter
  import mapping_pkg::*;
#(
  parameter int BS = DEF_BS,
  parameter int DW = DEF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [0:BS-1]         candidate_list,
  output logic                  load_ready,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BS*DW-1:0]      out_data,
  output logic [0:BS-1]         out_mask,
  output logic [$clog2(BS):0]   remaining
);

  localparam int IW = $clog2(BS);
  localparam int RW = IW + 1;

  state_e          r_state;
  logic [0:BS-1]   r_pending;
  logic [0:BS-1]   r_mask;
  logic [BS*DW-1:0] r_data;
  logic [RW-1:0]   r_remaining;

  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [RW-1:0]   w_pop;

  lowest_one_enc #(
    .BS (BS),
    .IW (IW)
  ) u_enc (
    .i_vec (r_pending),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < BS; i++) begin
      w_pop = w_pop + RW'(candidate_list[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_mask      <= '0;
      r_data      <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (load) begin
            r_mask      <= candidate_list;
            r_pending   <= candidate_list;
            r_remaining <= w_pop;
`ifdef MAPPING_SCATTER_HOLD_EN
`else
            r_data      <= '0;
`endif
            r_state     <= (|candidate_list) ? SCATTER : DONE;
          end
        end
        SCATTER: begin
          // Beat n lands on the n-th lowest selected slot, mirroring compaction order.
          if (in_valid && w_any) begin
            r_data[int'(w_idx)*DW +: DW] <= in_data;
            r_pending[w_idx]             <= 1'b0;
            r_remaining                  <= r_remaining - RW'(1);
            if (r_remaining == RW'(1)) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign load_ready = (r_state == IDLE);
  assign in_ready   = (r_state == SCATTER);
  assign out_valid  = (r_state == DONE);
  assign out_data   = r_data;
  assign out_mask   = r_mask;
  assign remaining  = r_remaining;

endmodule

// File: tb/tb_mapping_scatter.sv
// Directed bench for mapping_scatter with a queue-based scoreboard of expected result vectors.
module tb_mapping_scatter;
  localparam int BS = 16;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [0:BS-1]     candidate_list;
  logic              load_ready;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [BS*DW-1:0]  out_data;
  logic [0:BS-1]     out_mask;
  logic [4:0]        remaining;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int load_cyc;
  int rem_exp;

  logic [127:0] mdl = '0;
  logic [127:0] exp_q[$];
  logic [0:15]  mask_q[$];
  logic [7:0]   beats[16];

  mapping_scatter #(.BS(BS), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .candidate_list (candidate_list),
    .load_ready     (load_ready),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_mask       (out_mask),
    .remaining      (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one load; the model builds the expected vector from beats[] in mask order.
  task automatic do_load(input logic [15:0] ms);
    logic [0:15]  m;
    logic [127:0] e;
    int           k;
    for (int i = 0; i < 16; i++) m[i] = ms[i];
    @(negedge clk);
    load = 1'b1;
    candidate_list = m;
    @(negedge clk);
    load = 1'b0;
    load_cyc = cyc;
`ifdef MAPPING_SCATTER_HOLD_EN
    e = mdl;
`else
    e = '0;
`endif
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        e[i*8 +: 8] = beats[k];
        k++;
      end
    end
    mdl = e;
    exp_q.push_back(e);
    mask_q.push_back(m);
    rem_exp = $countones(ms);
    chk("load_remaining", remaining, rem_exp);
  endtask

  task automatic send_beats(input int first, input int n, input int gap);
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      in_data  = beats[first + b];
      @(negedge clk);
      in_valid = 1'b0;
      rem_exp--;
      chk("beat_remaining", remaining, rem_exp);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic finish_frame(input int exp_lat, input int hold);
    int           n;
    logic [127:0] e;
    logic [0:15]  m;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk("out_valid_timeout", out_valid, 1'b1);
      return;
    end
    if (exp_lat >= 0) chk("latency", cyc - load_cyc, exp_lat);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    chk("out_data", out_data, e);
    chk("out_mask", out_mask, m);
    chk("done_remaining", remaining, 0);
    chk("done_in_ready", in_ready, 0);
    chk("done_load_ready", load_ready, 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("accept_load_ready", load_ready, 1'b1);
    chk("accept_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    candidate_list = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beats[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask", out_mask, '0);
    chk("rst_remaining", remaining, 0);

    // Beat offered in IDLE must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_beat_data", out_data, '0);
    chk("idle_beat_ready", load_ready, 1'b1);

    // Slots 2, 5, 11, no stalls.
    beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3;
    do_load(16'h0824);
    chk("t1_in_ready", in_ready, 1'b1);
    send_beats(0, 3, 0);
    finish_frame(3, 0);

    // Same frame, toggling in_valid and stalled consumer.
    do_load(16'h0824);
    send_beats(0, 3, 1);
    finish_frame(-1, 5);

    // Empty mask goes straight to DONE.
    do_load(16'h0000);
    chk("t3_in_ready", in_ready, 1'b0);
    finish_frame(0, 0);

    // All-ones mask with a load pulse mid-frame.
    for (int i = 0; i < 16; i++) beats[i] = 8'(i);
    do_load(16'hFFFF);
    send_beats(0, 5, 0);
    load = 1'b1;
    candidate_list = 16'h8000;
    @(negedge clk);
    load = 1'b0;
    chk("t4_ignored_load_rem", remaining, rem_exp);
    chk("t4_ignored_load_rdy", in_ready, 1'b1);
    send_beats(5, 11, 0);
    finish_frame(-1, 0);

    // Reset after 2 of 3 beats.
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    do_load(16'h0211);
    send_beats(0, 2, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_load_ready", load_ready, 1'b1);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_data", out_data, '0);
    chk("mid_rst_out_mask", out_mask, '0);
    chk("mid_rst_remaining", remaining, 0);
    exp_q.delete();
    mask_q.delete();
    mdl = '0;
    beats[0] = 8'h11; beats[1] = 8'h33;
    do_load(16'h000A);
    send_beats(0, 2, 0);
    finish_frame(2, 0);

    // Hold behaviour: 0x55 everywhere, then only slot 7 rewritten.
    for (int i = 0; i < 16; i++) beats[i] = 8'h55;
    do_load(16'hFFFF);
    send_beats(0, 16, 0);
    finish_frame(16, 0);
    beats[0] = 8'h99;
    do_load(16'h0080);
    send_beats(0, 1, 0);
    finish_frame(1, 0);
    chk("hold_slot7", out_data[7*8 +: 8], 8'h99);
`ifdef MAPPING_SCATTER_HOLD_EN
    chk("hold_slot0", out_data[7:0], 8'h55);
`else
    chk("hold_slot0", out_data[7:0], 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mapping_scatter.md
# mapping_scatter

Inverse of the candidate-compaction stage. It accepts a candidate bitmask, then consumes a stream of compacted data beats, one per selected slot. Each beat is written back to its original slot position. When every selected slot is filled, it presents the full BS-slot result vector. It sits downstream of the compacted processing path and restores the sparse, slot-indexed layout.

## Interface
- BS, 16: number of slots; power of two, ≥2.
- DW, 8: data width per slot.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  start a frame with candidate_list; accepted only when load_ready=1.
- candidate_list  in  [0:BS-1]  bit i=1 means slot i is selected.
- load_ready  out  1  high in IDLE only.
- in_valid  in  1  compacted beat valid.
- in_data  in  DW  compacted beat payload.
- in_ready  out  1  high in SCATTER only.
- out_valid  out  1  full vector available; high in DONE only.
- out_ready  in  1  consumer accepts the vector.
- out_data  out  BS*DW  slot i at out_data[i*DW +: DW].
- out_mask  out  [0:BS-1]  captured candidate_list of the current frame.
- remaining  out  $clog2(BS)+1  selected slots not yet filled.

## Operation
- Pending mask register: set to candidate_list on an accepted load; one bit clears per accepted beat.
- Target slot: the lowest-index set bit of the pending mask, where index 0 is candidate_list[0]. Beat n therefore goes to the n-th lowest selected index, matching compaction order.
- State IDLE:
  - load_ready=1.
  - On load, capture candidate_list into out_mask and pending mask.
  - Set remaining to the popcount of candidate_list.
  - Go to SCATTER, or to DONE if the mask is all zero.
- State SCATTER:
  - in_ready=1.
  - On in_valid, write in_data to the target slot, clear its pending bit and decrement remaining.
  - When the last pending bit clears, go to DONE.
- State DONE:
  - out_valid=1.
  - out_data, out_mask and remaining (=0) are held stable until out_ready, then go to IDLE.
- Unselected slots: cleared to 0 on an accepted load (see Configuration).
- Handshake rules:
  - load while not IDLE is ignored.
  - in_valid outside SCATTER is ignored; no beat is consumed.
  - out_ready outside DONE is ignored.
  - out_valid must not drop before acceptance.
- Reset (any state, including mid-frame):
  - Next state IDLE.
  - out_data=0, out_mask=0, pending=0, remaining=0.
  - out_valid=0, in_ready=0, load_ready=1.
  - Any in-flight beats are dropped.

## Timing
- Load accepted at edge t: SCATTER (or DONE if the mask is empty) is visible after t. in_ready=1 from cycle t+1.
- Throughput is one beat per cycle. A beat accepted at edge k is visible in out_data after k.
- Last beat at edge k gives out_valid=1 in cycle k+1. Accepting the vector at edge m gives load_ready=1 in cycle m+1.
- Frame latency for P selected slots with no stalls: P+1 cycles from load to out_valid.
- There is no combinational path from in_valid, out_ready or load to any output. All outputs are registered or decoded from state.

## Configuration
- MAPPING_SCATTER_HOLD_EN:
  - Defined: unselected slots keep their previous frame's values on load; only selected slots are overwritten.
  - Undefined: unselected slots are zeroed on load.
  - Reset clears out_data to 0 in both builds.

## Structure
- Package mapping_pkg holds:
  - state enum {IDLE, SCATTER, DONE};
  - BS_BITS = $clog2(BS) helper;
  - default BS/DW constants shared with the compaction stage.
- One sub-module, lowest_one_enc: combinational BS-bit priority encoder giving the lowest set index plus an any-set flag.
- Popcount is inline.

## Test plan
- BS=16, DW=8. Load mask with bits 2, 5, 11 set; beats 0xA1, 0xB2, 0xC3 with no stalls.
  - Slot 2=0xA1, slot 5=0xB2, slot 11=0xC3, all others 0.
  - out_valid in cycle 4 after load; remaining 3→0.
- Same frame with in_valid toggling 1,0,1,0,1 and out_ready held low 5 cycles.
  - Same slot contents.
  - out_data stable while out_valid is high; IDLE one cycle after out_ready.
- All-zero mask load.
  - DONE next cycle, out_valid=1, remaining=0, out_data=0; in_ready never high.
- All-ones mask; beats 0x00..0x0F.
  - Slot i=i for every slot.
  - load pulsed during SCATTER is ignored; out_mask unchanged.
- rst asserted after 2 of 3 beats.
  - Next cycle: IDLE, outputs all 0.
  - A subsequent frame with bits 1 and 3 set completes correctly.
- HOLD_EN build: frame 1 all-ones with 0x55 everywhere, then frame 2 with only bit 7 set and beat 0x99.
  - Slot 7=0x99, other slots 0x55.
  - Without HOLD_EN the other slots are 0.
